// File: rtl/reset_sequencer_if.sv
// Lock/ready inputs and sequenced reset/status outputs of reset_sequencer.
// The sequencer uses the master modport. The environment and stages use the slave modport.
interface reset_sequencer_if #(
  parameter int unsigned NUM_STAGE = 4
);
  logic                 i_pll_locked;
  logic [NUM_STAGE-1:0] i_stage_ready;
  logic [NUM_STAGE-1:0] o_srst;
  logic                 o_done;
  logic                 o_fault;
  logic [3:0]           o_fault_stage;

  modport master (
    input  i_pll_locked,
    input  i_stage_ready,
    output o_srst,
    output o_done,
    output o_fault,
    output o_fault_stage
  );

  modport slave (
    output i_pll_locked,
    output i_stage_ready,
    input  o_srst,
    input  o_done,
    input  o_fault,
    input  o_fault_stage
  );
endinterface

// File: rtl/reset_sequencer.sv
// Waits for a stable PLL lock, then releases NUM_STAGE resets one at a time in index order.
// Define RESET_SEQ_TIMEOUT_EN to enable the stage-ready timeout and the absorbing FAULT state.
module reset_sequencer #(
  parameter int unsigned          NUM_STAGE      = 4,
  parameter int unsigned          DELAY_CYCLE    = 16,
  parameter int unsigned          TIMEOUT_CYCLE  = 1024,
  parameter logic [NUM_STAGE-1:0] OUT_RST_ACTIVE = '1
) (
  input  logic              i_clk,
  input  logic              i_srst,
  reset_sequencer_if.master bus
);

  localparam int unsigned CNT_MAX = (DELAY_CYCLE > TIMEOUT_CYCLE) ? DELAY_CYCLE : TIMEOUT_CYCLE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned K_W     = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;

  localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM_STAGE - 1);
  localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(DELAY_CYCLE);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYCLE - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLE - 1);
`endif

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_DELAY,
    ST_WAIT_READY,
    ST_DONE,
    ST_FAULT
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [NUM_STAGE-1:0] srst_q, srst_d;
  logic [NUM_STAGE-1:0] rel_c, rel_d;
  logic                 done_q, done_d;
  logic                 lock_lost_c;
`ifdef RESET_SEQ_TIMEOUT_EN
  logic                 fault_q, fault_d;
  logic [3:0]           fstage_q, fstage_d;
`endif

  // Released mask, recovered from the polarity-applied output register.
  assign rel_c = srst_q ^ OUT_RST_ACTIVE;

  assign lock_lost_c = !bus.i_pll_locked &&
                       (state_q inside {ST_DELAY, ST_WAIT_READY, ST_DONE});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    rel_d   = rel_c;
    done_d  = done_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    fault_d  = fault_q;
    fstage_d = fstage_q;
`endif

    // Lock loss outranks any ready or timeout seen in the same cycle.
    if (lock_lost_c) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      k_d     = '0;
      rel_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          if (!bus.i_pll_locked) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_CNT) begin
            state_d = ST_DELAY;
            cnt_d   = '0;
            k_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DELAY: begin
          if (cnt_q == DLY_LAST) begin
            rel_d[k_q] = 1'b1;
            state_d    = ST_WAIT_READY;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_WAIT_READY: begin
          if (bus.i_stage_ready[k_q]) begin
            cnt_d = '0;
            if (k_q == K_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              k_d     = k_q + K_W'(1);
              state_d = ST_DELAY;
            end
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            state_d  = ST_FAULT;
            fault_d  = 1'b1;
            fstage_d = 4'(k_q);
            rel_d    = '0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end

        ST_DONE:  ;
        ST_FAULT: rel_d = '0;
        default:  state_d = ST_WAIT_LOCK;
      endcase
    end

    srst_d = rel_d ^ OUT_RST_ACTIVE;
  end

  // Synchronous reset returns everything to WAIT_LOCK with all stages held.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q  <= ST_WAIT_LOCK;
      cnt_q    <= '0;
      k_q      <= '0;
      srst_q   <= OUT_RST_ACTIVE;
      done_q   <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      fault_q  <= 1'b0;
      fstage_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      srst_q   <= srst_d;
      done_q   <= done_d;
`ifdef RESET_SEQ_TIMEOUT_EN
      fault_q  <= fault_d;
      fstage_q <= fstage_d;
`endif
    end
  end

  assign bus.o_srst = srst_q;
  assign bus.o_done = done_q;
`ifdef RESET_SEQ_TIMEOUT_EN
  assign bus.o_fault       = fault_q;
  assign bus.o_fault_stage = fstage_q;
`else
  assign bus.o_fault       = 1'b0;
  assign bus.o_fault_stage = 4'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_STAGE=3, DELAY_CYCLE=4, TIMEOUT_CYCLE=8, OUT_RST_ACTIVE=3'b101.
// Edge 0 is the first rising edge with i_srst low. The timeout section runs only with RESET_SEQ_TIMEOUT_EN.
module tb_reset_sequencer;

  localparam int unsigned N = 3;
  localparam int unsigned D = 4;
  localparam int unsigned T = 8;
  localparam logic [2:0]  ACT     = 3'b101;
  localparam logic [2:0]  ALL_REL = 3'b010;
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int unsigned HOLD = 5;
`else
  localparam int unsigned HOLD = 20;
`endif

  logic clk;
  logic srst;
  int   checks;
  int   errors;

  reset_sequencer_if #(.NUM_STAGE(N)) bus ();

  reset_sequencer #(
    .NUM_STAGE      (N),
    .DELAY_CYCLE    (D),
    .TIMEOUT_CYCLE  (T),
    .OUT_RST_ACTIVE (ACT)
  ) dut (
    .i_clk  (clk),
    .i_srst (srst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One reset edge, then reset released so the following edge is edge 0.
  task automatic pulse_reset(input string tag);
    srst = 1'b1;
    tick();
    chk({tag, "_srst"},  32'(bus.o_srst), 32'(ACT));
    chk({tag, "_done"},  32'(bus.o_done), 32'd0);
    chk({tag, "_fault"}, 32'(bus.o_fault), 32'd0);
    chk({tag, "_fstg"},  32'(bus.o_fault_stage), 32'd0);
    srst = 1'b0;
  endtask

  // Lock is high from edge 0; each ready is returned two edges after its release.
  task automatic run_nominal(input string tag);
    logic [2:0] rel;
    rel = '0;
    repeat (2 * D) tick();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("%s_hold%0d", tag, s), 32'(bus.o_srst), 32'(ACT ^ rel));
      tick();
      rel[s] = 1'b1;
      chk($sformatf("%s_rel%0d", tag, s), 32'(bus.o_srst), 32'(ACT ^ rel));
      chk($sformatf("%s_ndone%0d", tag, s), 32'(bus.o_done), 32'd0);
      tick();
      bus.i_stage_ready = 3'(32'd1 << s);
      tick();
      bus.i_stage_ready = '0;
      if (s < 2) repeat (D - 1) tick();
    end
    chk({tag, "_done"}, 32'(bus.o_done), 32'd1);
    chk({tag, "_final"}, 32'(bus.o_srst), 32'(ALL_REL));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    srst = 1'b1;
    bus.i_pll_locked  = 1'b0;
    bus.i_stage_ready = '0;
    tick();
    tick();
    chk("rst_srst",  32'(bus.o_srst), 32'h5);
    chk("rst_done",  32'(bus.o_done), 32'd0);
    chk("rst_fault", 32'(bus.o_fault), 32'd0);
    chk("rst_fstg",  32'(bus.o_fault_stage), 32'd0);

    // Nominal sequence: stage 0 releases at edge 8.
    srst = 1'b0;
    bus.i_pll_locked = 1'b1;
    run_nominal("nom");

    // Reset pulse while in DONE, then a clean restart.
    pulse_reset("done_rst");
    run_nominal("restart");

    // Lock glitch: high at edges 0-2, low at edge 3, so stage 0 releases at edge 12.
    pulse_reset("glitch_rst");
    tick();
    tick();
    tick();
    bus.i_pll_locked = 1'b0;
    tick();
    bus.i_pll_locked = 1'b1;
    run_nominal("glitch");

    // Lock lost in WAIT_READY of stage 1, with a simultaneous ready that must lose.
    pulse_reset("ll_rst");
    repeat (2 * D + 1) tick();
    chk("ll_rel0", 32'(bus.o_srst), 32'h4);
    tick();
    bus.i_stage_ready = 3'b001;
    tick();
    bus.i_stage_ready = '0;
    repeat (D) tick();
    chk("ll_rel1", 32'(bus.o_srst), 32'h6);
    bus.i_pll_locked  = 1'b0;
    bus.i_stage_ready = 3'b010;
    tick();
    chk("ll_srst", 32'(bus.o_srst), 32'h5);
    chk("ll_done", 32'(bus.o_done), 32'd0);
    bus.i_stage_ready = '0;
    repeat (3) tick();
    chk("ll_held", 32'(bus.o_srst), 32'h5);
    bus.i_pll_locked = 1'b1;
    run_nominal("relock");

    // Early and foreign ready: 3'b110 held from edge 0 does not release stage 0's wait.
    bus.i_stage_ready = 3'b110;
    pulse_reset("early_rst");
    repeat (2 * D) tick();
    chk("early_pre", 32'(bus.o_srst), 32'h5);
    tick();
    chk("early_rel0", 32'(bus.o_srst), 32'h4);
    repeat (HOLD) tick();
    chk("early_wait", 32'(bus.o_srst), 32'h4);
    chk("early_ndone", 32'(bus.o_done), 32'd0);
    chk("early_nfault", 32'(bus.o_fault), 32'd0);
    bus.i_stage_ready = 3'b111;
    tick();
    repeat (D - 1) tick();
    chk("early_dly1", 32'(bus.o_srst), 32'h4);
    tick();
    chk("early_rel1", 32'(bus.o_srst), 32'h6);
    tick();
    repeat (D - 1) tick();
    chk("early_dly2", 32'(bus.o_srst), 32'h6);
    tick();
    chk("early_rel2", 32'(bus.o_srst), 32'h2);
    chk("early_ndone2", 32'(bus.o_done), 32'd0);
    tick();
    chk("early_done", 32'(bus.o_done), 32'd1);
    chk("early_fault", 32'(bus.o_fault), 32'd0);
    bus.i_stage_ready = '0;

`ifdef RESET_SEQ_TIMEOUT_EN
    // Stage 1 never reports ready: fault eight edges after its release (edge 22).
    pulse_reset("to_rst");
    repeat (2 * D + 1) tick();
    tick();
    bus.i_stage_ready = 3'b001;
    tick();
    bus.i_stage_ready = '0;
    repeat (D) tick();
    chk("to_rel1", 32'(bus.o_srst), 32'h6);
    repeat (T - 1) tick();
    chk("to_nfault", 32'(bus.o_fault), 32'd0);
    tick();
    chk("to_fault", 32'(bus.o_fault), 32'd1);
    chk("to_fstg",  32'(bus.o_fault_stage), 32'd1);
    chk("to_srst",  32'(bus.o_srst), 32'h5);
    bus.i_pll_locked = 1'b0;
    repeat (2) tick();
    bus.i_pll_locked = 1'b1;
    repeat (10) tick();
    chk("to_stuck", 32'(bus.o_fault), 32'd1);
    chk("to_stuck_srst", 32'(bus.o_srst), 32'h5);
    pulse_reset("to_clear");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGE, default 4: number of sequenced reset outputs, range 1..16.
REQ-002 Parameter DELAY_CYCLE, default 16: stable-lock and inter-stage delay in i_clk cycles, minimum 1.
REQ-003 Parameter TIMEOUT_CYCLE, default 1024: stage-ready timeout in i_clk cycles, minimum 1.
REQ-004 Parameter OUT_RST_ACTIVE, default all ones: per-bit polarity mask; bit k = 1 means o_srst[k] is active-high, 0 means active-low.
REQ-005 Port i_clk, input, 1: the single clock; every register in the block SHALL be clocked on its rising edge.
REQ-006 Port i_srst, input, 1: reset, synchronous and active-high.
REQ-007 Port i_pll_locked, input, 1: clock-source lock, synchronous to i_clk.
REQ-008 Port i_stage_ready, input, NUM_STAGE: bit k = stage k reports it is out of reset.
REQ-009 Port o_srst, output, NUM_STAGE: sequenced resets, with polarity set by OUT_RST_ACTIVE.
REQ-010 Port o_done, output, 1: high when all stages are released and ready.
REQ-011 Port o_fault, output, 1: high when a stage-ready timeout has occurred.
REQ-012 Port o_fault_stage, output, 4: index of the stage that timed out.

Function
REQ-013 States: WAIT_LOCK, DELAY, WAIT_READY, DONE, FAULT; a stage index k (0..NUM_STAGE-1) and a single cycle counter.
REQ-014 WAIT_LOCK: counter increments while i_pll_locked=1 and clears to 0 when i_pll_locked=0.
REQ-015 WAIT_LOCK exit: after DELAY_CYCLE consecutive high samples, go to DELAY with k=0.
REQ-016 DELAY: counter counts DELAY_CYCLE cycles; on the final count, o_srst[k] deasserts at that edge and the state goes to WAIT_READY with the counter cleared.
REQ-017 Stage 0 release: deasserts exactly 2*DELAY_CYCLE cycles after the first of the consecutive lock-high samples.
REQ-018 WAIT_READY: i_stage_ready[k] is sampled from the first cycle after release; i_stage_ready bits other than k, and any ready seen earlier, SHALL be ignored.
REQ-019 WAIT_READY with i_stage_ready[k]=1 and k<NUM_STAGE-1: k increments and the state goes to DELAY.
REQ-020 WAIT_READY with i_stage_ready[k]=1 and k=NUM_STAGE-1: go to DONE; o_done=1 from the next cycle.
REQ-021 Released stages stay released while later stages sequence; outputs release strictly in index order, one at a time.
REQ-022 Lock loss: i_pll_locked=0 in DELAY, WAIT_READY or DONE reasserts all o_srst at the next edge, clears o_done, k and counter, and returns to WAIT_LOCK.
REQ-023 Lock loss priority: lock loss SHALL win over a simultaneous ready or timeout in the same cycle.
REQ-024 FAULT: absorbing; all o_srst asserted, o_fault=1, i_pll_locked ignored; exit only via i_srst.
REQ-025 Counter width: sized for max(DELAY_CYCLE, TIMEOUT_CYCLE); the counter SHALL never wrap.

Reset
REQ-026 i_srst=1 at a rising edge SHALL, at that edge, assert all o_srst (per polarity), and set o_done=0, o_fault=0, o_fault_stage=0, k=0, counter=0, state=WAIT_LOCK.
REQ-027 i_srst mid-sequence, in DONE, or in FAULT SHALL have the identical effect; i_srst overrides all other inputs.
REQ-028 Sequencing SHALL resume from WAIT_LOCK on the first edge with i_srst=0.

Configuration
REQ-029 Macro RESET_SEQ_TIMEOUT_EN defined: WAIT_READY counts cycles, and reaching TIMEOUT_CYCLE without ready moves to FAULT with o_fault_stage=k and all o_srst reasserted at that edge.
REQ-030 Macro RESET_SEQ_TIMEOUT_EN undefined: WAIT_READY waits indefinitely, FAULT is unreachable, and o_fault and o_fault_stage are constant 0.

Verification (NUM_STAGE=3, DELAY_CYCLE=4, TIMEOUT_CYCLE=8, OUT_RST_ACTIVE=3'b101)
REQ-031 Nominal: lock high from cycle 0, each ready returned 2 cycles after its release -> o_srst[0] releases at cycle 8, then stages 1 and 2 in order; o_done=1; released levels are 0,1,0 for bits 0,1,2.
REQ-032 Lock glitch: lock high for 3 cycles, low for 1, then high -> no release until 8 cycles after the re-rise.
REQ-033 Lock lost in WAIT_READY of stage 1 -> next edge shows all o_srst asserted and o_done=0; the full sequence repeats after lock returns.
REQ-034 Timeout (macro defined): stage 1 ready never asserted -> 8 cycles after its release o_fault=1, o_fault_stage=1, all o_srst asserted; lock toggling has no effect; i_srst clears the fault.
REQ-035 Early and foreign ready: i_stage_ready=3'b110 held from cycle 0 -> stage 0 still waits for its own bit and no stage skips its DELAY; with the macro undefined, o_fault stays 0 indefinitely.
REQ-036 i_srst pulsed for 1 cycle in DONE -> all o_srst asserted and o_done=0 at that edge; the sequence restarts correctly.
